// File: rtl/sys_defs.sv
// Shared types for the reservation station: ROB tags, FU kinds and the RS entry layout.
package sys_defs;
   localparam int SYS_XLEN      = 32;
   localparam int SYS_ROB_TAG_W = 3;
   localparam int SYS_NUM_FU    = 4;
   localparam int SYS_FU_W      = 2;

   typedef logic [SYS_ROB_TAG_W-1:0] ROB_TAG;
   localparam ROB_TAG ROB_TAG_NONE = '0;

   typedef enum logic [SYS_FU_W-1:0] {ALU, Load, Store, FloatingPoint} FU_TYPE;

   typedef struct packed {
      logic                busy;
      FU_TYPE              fu;
      ROB_TAG              t1;
      ROB_TAG              t2;
      logic [SYS_XLEN-1:0] v1;
      logic [SYS_XLEN-1:0] v2;
      logic                rdy1;
      logic                rdy2;
      ROB_TAG              rob;
      logic [31:0]         inst;
   } RS_MI_ENTRY;
endpackage

// File: rtl/rs_pick_lowest.sv
// Priority encoder: grants the lowest-index set bit of req, with its index and a found flag.
module rs_pick_lowest #(
   parameter int N = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          found
);
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      // Scan downward so the lowest requester is the one left standing.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt    = '0;
            gnt[i] = 1'b1;
            idx    = IW'(i);
            found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/rs_multi_issue.sv
// Unified reservation station: per-entry FU type, CDB wakeup, one issue port per FU, full flush.
module rs_multi_issue
   import sys_defs::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int NUM_FU      = SYS_NUM_FU,
   parameter int XLEN        = SYS_XLEN,
   parameter int ROB_TAG_W   = SYS_ROB_TAG_W,
   localparam int FU_IW      = $clog2(NUM_FU),
   localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   input  logic [FU_IW-1:0]          alloc_fu,
   input  logic [31:0]               alloc_inst,
   input  logic [ROB_TAG_W-1:0]      alloc_rob,
   input  logic [ROB_TAG_W-1:0]      alloc_t1,
   input  logic [ROB_TAG_W-1:0]      alloc_t2,
   input  logic [XLEN-1:0]           alloc_v1,
   input  logic [XLEN-1:0]           alloc_v2,
   input  logic                      cdb_valid,
   input  logic [ROB_TAG_W-1:0]      cdb_tag,
   input  logic [XLEN-1:0]           cdb_value,
   output logic [NUM_FU-1:0]         issue_valid,
   input  logic [NUM_FU-1:0]         issue_ready,
   output logic [NUM_FU*32-1:0]      issue_inst,
   output logic [NUM_FU*ROB_TAG_W-1:0] issue_rob,
   output logic [NUM_FU*XLEN-1:0]    issue_v1,
   output logic [NUM_FU*XLEN-1:0]    issue_v2,
   output logic [CNT_W-1:0]          free_count
);
   localparam int IDX_W = $clog2(NUM_ENTRIES);

   RS_MI_ENTRY ent [NUM_ENTRIES];
   RS_MI_ENTRY alloc_ent;

   logic [NUM_ENTRIES-1:0]             busy_vec, alloc_gnt, clear_vec;
   logic [NUM_FU-1:0][NUM_ENTRIES-1:0] ready_vec, issue_gnt;
   logic [NUM_FU-1:0][IDX_W-1:0]       issue_idx;
   logic [NUM_FU-1:0]                  issue_found, issue_fire;
   logic [IDX_W-1:0]                   unused_alloc_idx;
   logic                               unused_alloc_found;
   logic                               alloc_fire;
   logic [CNT_W-1:0]                   issued_cnt;

   assign alloc_ready = (free_count != '0);
   assign alloc_fire  = alloc_valid & alloc_ready;

   for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
      assign busy_vec[i] = ent[i].busy;
      for (genvar f = 0; f < NUM_FU; f++) begin : g_req
         assign ready_vec[f][i] = ent[i].busy & ent[i].rdy1 & ent[i].rdy2 &
                                  (ent[i].fu == FU_TYPE'(f));
      end
   end

   rs_pick_lowest #(.N(NUM_ENTRIES)) u_alloc_pick (
      .req(~busy_vec), .gnt(alloc_gnt), .idx(unused_alloc_idx), .found(unused_alloc_found)
   );

   for (genvar f = 0; f < NUM_FU; f++) begin : g_fu
      rs_pick_lowest #(.N(NUM_ENTRIES)) u_issue_pick (
         .req(ready_vec[f]), .gnt(issue_gnt[f]), .idx(issue_idx[f]), .found(issue_found[f])
      );
      assign issue_valid[f]                       = issue_found[f];
      assign issue_fire[f]                        = issue_found[f] & issue_ready[f];
      assign issue_inst[f*32 +: 32]               = issue_found[f] ? ent[issue_idx[f]].inst : '0;
      assign issue_rob[f*ROB_TAG_W +: ROB_TAG_W]  = issue_found[f] ? ent[issue_idx[f]].rob  : '0;
      assign issue_v1[f*XLEN +: XLEN]             = issue_found[f] ? ent[issue_idx[f]].v1   : '0;
      assign issue_v2[f*XLEN +: XLEN]             = issue_found[f] ? ent[issue_idx[f]].v2   : '0;
   end

   always_comb begin
      clear_vec  = '0;
      issued_cnt = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         if (issue_fire[f]) begin
            clear_vec  = clear_vec | issue_gnt[f];
            issued_cnt = issued_cnt + CNT_W'(1);
         end
      end
   end

   // A source whose producer broadcasts in the allocation cycle is captured directly.
   always_comb begin
      alloc_ent      = '0;
      alloc_ent.busy = 1'b1;
      alloc_ent.fu   = FU_TYPE'(alloc_fu);
      alloc_ent.rob  = alloc_rob;
      alloc_ent.inst = alloc_inst;
      if (alloc_t1 == ROB_TAG_NONE) begin
         alloc_ent.rdy1 = 1'b1;
         alloc_ent.v1   = alloc_v1;
      end else if (cdb_valid && cdb_tag == alloc_t1) begin
         alloc_ent.rdy1 = 1'b1;
         alloc_ent.v1   = cdb_value;
      end else begin
         alloc_ent.t1   = alloc_t1;
      end
      if (alloc_t2 == ROB_TAG_NONE) begin
         alloc_ent.rdy2 = 1'b1;
         alloc_ent.v2   = alloc_v2;
      end else if (cdb_valid && cdb_tag == alloc_t2) begin
         alloc_ent.rdy2 = 1'b1;
         alloc_ent.v2   = cdb_value;
      end else begin
         alloc_ent.t2   = alloc_t2;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
         free_count <= CNT_W'(NUM_ENTRIES);
      end else if (flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) ent[i] <= '0;
         free_count <= CNT_W'(NUM_ENTRIES);
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent[i].busy && cdb_valid && cdb_tag != ROB_TAG_NONE) begin
               if (!ent[i].rdy1 && ent[i].t1 == cdb_tag) begin
                  ent[i].v1   <= cdb_value;
                  ent[i].rdy1 <= 1'b1;
                  ent[i].t1   <= ROB_TAG_NONE;
               end
               if (!ent[i].rdy2 && ent[i].t2 == cdb_tag) begin
                  ent[i].v2   <= cdb_value;
                  ent[i].rdy2 <= 1'b1;
                  ent[i].t2   <= ROB_TAG_NONE;
               end
            end
            if (clear_vec[i]) ent[i].busy <= 1'b0;
            // Only a non-busy entry is granted, so this never collides with wakeup or clear.
            if (alloc_fire && alloc_gnt[i]) ent[i] <= alloc_ent;
         end
         free_count <= free_count - CNT_W'(alloc_fire) + issued_cnt;
      end
   end
endmodule

// File: tb/tb_rs_multi_issue.sv
// Directed bench for rs_multi_issue: allocation, wakeup, bypass, multi-issue, full, flush, reset.
module tb_rs_multi_issue;
   localparam int NE = 8;
   localparam int NF = 4;
   localparam int XL = 32;
   localparam int TW = 3;

   logic            clock = 1'b0;
   logic            reset, flush, alloc_valid, alloc_ready, cdb_valid;
   logic [1:0]      alloc_fu;
   logic [31:0]     alloc_inst;
   logic [TW-1:0]   alloc_rob, alloc_t1, alloc_t2, cdb_tag;
   logic [XL-1:0]   alloc_v1, alloc_v2, cdb_value;
   logic [NF-1:0]   issue_valid, issue_ready;
   logic [NF*32-1:0] issue_inst;
   logic [NF*TW-1:0] issue_rob;
   logic [NF*XL-1:0] issue_v1, issue_v2;
   logic [3:0]      free_count;

   int checks = 0;
   int errors = 0;

   rs_multi_issue dut (
      .clock(clock), .reset(reset), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_fu(alloc_fu),
      .alloc_inst(alloc_inst), .alloc_rob(alloc_rob), .alloc_t1(alloc_t1), .alloc_t2(alloc_t2),
      .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
      .issue_rob(issue_rob), .issue_v1(issue_v1), .issue_v2(issue_v2),
      .free_count(free_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (alloc_valid && alloc_ready) assert (int'(alloc_fu) < NF);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      flush = 0; alloc_valid = 0; cdb_valid = 0; issue_ready = '0;
      alloc_fu = 0; alloc_inst = 0; alloc_rob = 0; alloc_t1 = 0; alloc_t2 = 0;
      alloc_v1 = 0; alloc_v2 = 0; cdb_tag = 0; cdb_value = 0;
   endtask

   task automatic set_alloc(input int fu, input int inst, input int rob,
                            input int t1, input int t2, input int v1, input int v2);
      alloc_valid = 1; alloc_fu = 2'(fu); alloc_inst = 32'(inst); alloc_rob = TW'(rob);
      alloc_t1 = TW'(t1); alloc_t2 = TW'(t2); alloc_v1 = XL'(v1); alloc_v2 = XL'(v2);
   endtask

   function automatic logic [31:0] inst_of(input int f);
      return issue_inst[f*32 +: 32];
   endfunction
   function automatic logic [XL-1:0] v1_of(input int f);
      return issue_v1[f*XL +: XL];
   endfunction
   function automatic logic [XL-1:0] v2_of(input int f);
      return issue_v2[f*XL +: XL];
   endfunction

   initial begin
      idle();
      reset = 1;
      #2;
      chk("rst_free", free_count, 8);
      chk("rst_ready", alloc_ready, 1);
      chk("rst_ivalid", issue_valid, 0);
      chk("rst_idata", {issue_inst, issue_rob}, 0);
      tick();
      reset = 0;
      tick();

      // Fill with 8 ready ALU ops, nothing accepted.
      for (int i = 0; i < NE; i++) begin
         set_alloc(0, 'h100 + i, i, 0, 0, i, i);
         tick();
         if (i == 0) begin
            chk("fill1_free", free_count, 7);
            chk("fill1_ivalid", issue_valid, 4'b0001);
         end
      end
      chk("full_ready", alloc_ready, 0);
      chk("full_free", free_count, 0);
      chk("full_ivalid", issue_valid, 4'b0001);
      chk("full_inst0", inst_of(0), 'h100);
      tick();  // alloc_valid still high while full
      chk("full_ignored", free_count, 0);

      // Issue one while full with alloc pending: no alloc this cycle.
      set_alloc(0, 'h55, 5, 0, 0, 0, 0);
      issue_ready = 4'b0001;
      tick();
      issue_ready = '0;
      chk("freed_count", free_count, 1);
      chk("freed_ready", alloc_ready, 1);
      chk("freed_next", inst_of(0), 'h101);
      tick();
      alloc_valid = 0;
      chk("realloc_count", free_count, 0);
      chk("realloc_idx0", inst_of(0), 'h55);

      flush = 1;
      tick();
      flush = 0;
      chk("flush1_free", free_count, 8);
      chk("flush1_ivalid", issue_valid, 0);

      // CDB wakeup two cycles after allocation.
      set_alloc(0, 'h200, 1, 3, 0, 0, 5);
      tick();
      alloc_valid = 0;
      chk("wait_c1", issue_valid, 0);
      tick();
      chk("wait_c2", issue_valid, 0);
      cdb_valid = 1; cdb_tag = 3; cdb_value = 'hA;
      #1;
      chk("no_comb_cdb", issue_valid, 0);
      tick();
      cdb_valid = 0;
      chk("wake_valid", issue_valid, 4'b0001);
      chk("wake_v1", v1_of(0), 'hA);
      chk("wake_v2", v2_of(0), 'h5);
      chk("wake_rob", issue_rob[2:0], 1);
      issue_ready = 4'b0001;
      tick();
      issue_ready = '0;
      chk("wake_freed", free_count, 8);

      // Same-cycle bypass into a FloatingPoint entry.
      set_alloc(3, 'h300, 2, 4, 0, 0, 0);
      cdb_valid = 1; cdb_tag = 4; cdb_value = 'h77;
      tick();
      idle();
      chk("byp_valid", issue_valid, 4'b1000);
      chk("byp_v1", v1_of(3), 'h77);
      issue_ready = 4'b1000;
      tick();
      issue_ready = '0;

      // One ready op per FU, all accepted together.
      for (int f = 0; f < NF; f++) begin
         set_alloc(f, 'h400 + f, f, 0, 0, f, 0);
         tick();
      end
      alloc_valid = 0;
      chk("quad_free", free_count, 4);
      chk("quad_valid", issue_valid, 4'b1111);
      chk("quad_inst2", inst_of(2), 'h402);
      issue_ready = 4'b1111;
      tick();
      issue_ready = '0;
      chk("quad_issued", free_count, 8);
      chk("quad_empty", issue_valid, 0);

      // Flush with busy entries and a concurrent alloc.
      set_alloc(0, 'h500, 1, 5, 0, 0, 0);
      tick();
      set_alloc(2, 'h501, 2, 0, 0, 0, 0);
      tick();
      chk("pre_flush_valid", issue_valid, 4'b0100);
      set_alloc(0, 'h502, 3, 0, 0, 0, 0);
      flush = 1; issue_ready = 4'b1111;
      tick();
      idle();
      chk("flush_valid", issue_valid, 0);
      chk("flush_free", free_count, 8);
      cdb_valid = 1; cdb_tag = 5; cdb_value = 'h9;
      tick();
      cdb_valid = 0;
      chk("flush_dropped", issue_valid, 0);

      // Async reset in the middle of a wakeup cycle.
      set_alloc(1, 'h600, 4, 6, 0, 0, 0);
      tick();
      alloc_valid = 0;
      chk("pre_rst_free", free_count, 7);
      cdb_valid = 1; cdb_tag = 6; cdb_value = 'h33;
      #2;
      reset = 1;
      #1;
      chk("arst_free", free_count, 8);
      chk("arst_ready", alloc_ready, 1);
      tick();
      cdb_valid = 0;
      reset = 0;
      tick();
      chk("arst_no_issue", issue_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
